// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (req0)
// and load (req1) writeback paths. Writes to $zero are dropped. Per-requester saturating counters are kept for debug.
module rf_wport_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic last;
  logic grant0;
  logic grant1;

  // Grant: a lone requester wins; under contention the one not granted last wins
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last);
    grant1 = req1_valid && (!req0_valid || !last);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Write-port register stage: winner's write is presented to the RF for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= 1'b1;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      cnt0     <= '0;
      cnt1     <= '0;
    end else if (grant0) begin
      last     <= 1'b0;
      rf_we    <= |req0_addr;
      rf_waddr <= req0_addr;
      rf_wdata <= req0_data;
      cnt0     <= sat_inc(cnt0);
    end else if (grant1) begin
      last     <= 1'b1;
      rf_we    <= |req1_addr;
      rf_waddr <= req1_addr;
      rf_wdata <= req1_data;
      cnt1     <= sat_inc(cnt1);
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: expected RF writes are queued as stimulus is driven
// and compared once the registered write appears. A small RF model tracks final register contents.
module tb_rf_wport_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [CW-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cnt0(cnt0), .cnt1(cnt1)
  );

  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           e;
  int            checks = 0;
  int            errors = 0;
  logic          s_r0, s_r1;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;

  // Drive one cycle of requests, sample grants before the edge, queue the expected write.
  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input int g);
    wr_t x;
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    if (g == 0) begin
      hold_addr = a0; hold_data = d0;
    end else if (g == 1) begin
      hold_addr = a1; hold_data = d1;
    end
    x.we   = (g >= 0) && (hold_addr != '0);
    x.addr = hold_addr;
    x.data = hold_data;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    hold_addr = '0;
    hold_data = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'd33;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'd44;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", rf_we); end
    checks++; if (cnt0 !== '0 || cnt1 !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt0, cnt1); end
    checks++; if (rf_waddr !== '0 || rf_wdata !== '0) begin errors++; $display("FAIL reset_port got %0d/%0d want 0/0", rf_waddr, rf_wdata); end
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL reset_ready got %b want 10", {req0_ready, req1_ready}); end
    checks++; if (rf_mem[3] !== '0 || rf_mem[4] !== '0) begin errors++; $display("FAIL reset_rfwrite got %0d/%0d want 0/0", rf_mem[3], rf_mem[4]); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    hold_addr = '0; hold_data = '0;
  endtask

  task automatic test_single();
    step(1'b1, 5'd5, 32'd4, 1'b0, 5'd0, 32'd0, 0);
    e = exp_q.pop_front();
    checks++; if ({s_r0, s_r1} !== 2'b10) begin errors++; $display("FAIL single_ready got %b want 10", {s_r0, s_r1}); end
    checks++; if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin errors++;
      $display("FAIL single_write got %0b/%0d/%0d want %0b/%0d/%0d", rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL single_cnt0 got %0d want 1", cnt0); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, -1);
    e = exp_q.pop_front();
    checks++; if ({s_r0, s_r1} !== 2'b00) begin errors++; $display("FAIL single_idle_ready got %b want 00", {s_r0, s_r1}); end
    checks++; if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin errors++;
      $display("FAIL single_idle got %0b/%0d/%0d want %0b/%0d/%0d", rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd1, 32'd53, 1'b1, 5'd2, 32'd6, i % 2);
      e = exp_q.pop_front();
      checks++; if ({s_r0, s_r1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL contention_grant[%0d] got %b want %b", i, {s_r0, s_r1}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      checks++; if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin errors++;
        $display("FAIL contention_write[%0d] got %0b/%0d/%0d want %0b/%0d/%0d", i, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
    end
    checks++; if (cnt0 !== 2'd2 || cnt1 !== 2'd2) begin errors++; $display("FAIL contention_cnt got %0d/%0d want 2/2", cnt0, cnt1); end
  endtask

  task automatic test_zero();
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd99, 1);
    e = exp_q.pop_front();
    checks++; if ({s_r0, s_r1} !== 2'b01) begin errors++; $display("FAIL zero_ready got %b want 01", {s_r0, s_r1}); end
    checks++; if (rf_we !== 1'b0 || e.we !== 1'b0 || rf_waddr !== e.addr || rf_wdata !== e.data) begin errors++;
      $display("FAIL zero_write got %0b/%0d/%0d want 0/%0d/%0d", rf_we, rf_waddr, rf_wdata, e.addr, e.data); end
    checks++; if (cnt1 !== 2'd3) begin errors++; $display("FAIL zero_cnt1 got %0d want 3", cnt1); end
    checks++; if (rf_mem[0] !== '0) begin errors++; $display("FAIL zero_rf0 got %0d want 0", rf_mem[0]); end
  endtask

  task automatic test_same_addr();
    step(1'b1, 5'd7, 32'd10, 1'b1, 5'd7, 32'd20, 0);
    e = exp_q.pop_front();
    checks++; if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin errors++;
      $display("FAIL same_first got %0b/%0d/%0d want %0b/%0d/%0d", rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd20, 1);
    e = exp_q.pop_front();
    checks++; if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin errors++;
      $display("FAIL same_second got %0b/%0d/%0d want %0b/%0d/%0d", rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
    checks++; if (rf_mem[7] !== 32'd10) begin errors++; $display("FAIL same_rf7_mid got %0d want 10", rf_mem[7]); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, -1);
    e = exp_q.pop_front();
    checks++; if (rf_mem[7] !== 32'd20) begin errors++; $display("FAIL same_rf7_final got %0d want 20", rf_mem[7]); end
  endtask

  task automatic test_saturation_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, AW'(i + 1), DW'(i * 3 + 1), 1'b0, 5'd0, 32'd0, 0);
      e = exp_q.pop_front();
      checks++; if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin errors++;
        $display("FAIL sat_write[%0d] got %0b/%0d/%0d want %0b/%0d/%0d", i, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
    end
    checks++; if (cnt0 !== 2'd3) begin errors++; $display("FAIL sat_cnt0 got %0d want 3", cnt0); end
    step(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0, 0);
    e = exp_q.pop_front();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin errors++; $display("FAIL midrst_pre got %0b/%0d want 1/9", rf_we, rf_waddr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midrst_we got %0b want 0", rf_we); end
    checks++; if (cnt0 !== '0) begin errors++; $display("FAIL midrst_cnt0 got %0d want 0", cnt0); end
    @(posedge clk); #1;
    checks++; if (rf_mem[9] !== '0) begin errors++; $display("FAIL midrst_rf9 got %0d want 0", rf_mem[9]); end
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    hold_addr = '0; hold_data = '0;
    test_reset();
    test_single();
    do_reset();
    test_contention();
    test_zero();
    do_reset();
    test_same_addr();
    do_reset();
    test_saturation_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single write port of the 32 x 32-bit register file between two writeback sources: requester 0 (ALU result) and requester 1 (load data). Arbitrates round-robin with a valid/ready handshake and registers the winning write onto the RF `we`/`waddr`/`wdata` lines. Suppresses writes to register `$zero` and keeps saturating per-requester write counters for debug. Sits between the writeback stage and the register file, which is built from `reg_32bits` instances.

## Interface
- `DATA_W`, 32, data width of each write.
- `ADDR_W`, 5, register address width (32 registers).
- `CNT_W`, 16, width of each saturating write counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0_valid`  in  1  requester 0 has a write pending.
- `req0_addr`  in  `ADDR_W`  destination register for requester 0.
- `req0_data`  in  `DATA_W`  write data for requester 0.
- `req0_ready`  out  1  grant to requester 0; combinational.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `rf_we`  out  1  registered write enable to the RF.
- `rf_waddr`  out  `ADDR_W`  registered write address.
- `rf_wdata`  out  `DATA_W`  registered write data.
- `cnt0`, `cnt1`  out  `CNT_W`  saturating count of accepted writes per requester; includes `$zero` writes.

## Operation
**Handshake**
- A transfer on requester i occurs in a cycle where `reqi_valid && reqi_ready` at the rising edge.
- `reqi_ready` is never high while `reqi_valid` is low.
- At most one of `req0_ready`/`req1_ready` is high in any cycle.
- A requester holds valid, addr and data stable until accepted. Behaviour is undefined if it does not.

**Arbitration**
- One state bit, `last`, records the last granted requester. It resets to 1, so requester 0 has priority first.
- Only one requester valid: that requester is granted.
- Both valid: the requester other than `last` is granted.
- Neither valid: no grant, and `last` is unchanged.
- `last` updates to the granted index on every transfer.
- Result: with both valid continuously, grants alternate 0,1,0,1,...

**Write port**
- On a transfer, the output registers load the winner's addr and data, and `rf_we <= (addr != 0)`.
- With no transfer, `rf_we <= 0`. `rf_waddr`/`rf_wdata` hold their previous values.
- Same-address requests from both sides in one cycle are not a special case. Normal round-robin applies, and the loser's write lands one cycle later, so the later write wins in the RF.

**Counters**
- `cnti` increments on each transfer of requester i, including writes to `$zero`.
- `cnti` saturates at 2^`CNT_W`-1 and does not wrap.

**Reset**
- All outputs reset to 0: `rf_we`, `rf_waddr`, `rf_wdata`, `cnt0`, `cnt1`. `last` resets to 1.
- `req*_ready` is combinational, so it tracks valid during reset. Grants shown during reset are not transfers: no state changes while `rst` is high.
- Reset asserted mid-operation drops any registered write. `rf_we` goes to 0 immediately, asynchronously. Requesters must re-present after reset.

## Timing
- Grant is same-cycle combinational: valid in cycle t gives ready in cycle t.
- Transfer at edge E puts `rf_we`/`rf_waddr`/`rf_wdata` on the RF during cycle E..E+1. The RF register `q` updates at edge E+1.
- Latency from request to RF contents is 2 edges. Throughput is one write per cycle.
- A losing requester waits at most 1 cycle under continuous contention.
- `rst` deassertion is synchronous to `clk` from the system. The first transfer can happen at the first edge with `rst` low.

## Test plan
- **Reset:** assert `rst` with both valid, addr=3 and 4 → `rf_we`=0, `cnt0`=`cnt1`=0; no RF write occurs.
- **Single requester:** `req0` valid, addr=5, data=4 for one cycle → `req0_ready`=1 that cycle; next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=4; `cnt0`=1; following cycle `rf_we`=0.
- **Contention:** both valid continuously for 4 cycles (`req0` addr=1 data=53, `req1` addr=2 data=6) → grants 0,1,0,1; `rf_waddr` sequence 1,2,1,2; `cnt0`=`cnt1`=2.
- **`$zero` suppression:** `req1` addr=0, data=99 → `req1_ready`=1, `cnt1` increments, `rf_we` stays 0.
- **Same address:** both valid to addr=7 (`req0` data=10, `req1` data=20) after reset → 10 is written first, then 20; RF reg 7 reads 20.
- **Saturation and mid-op reset:** with `CNT_W`=2, drive 5 transfers on `req0` → `cnt0`=3. Then pulse `rst` while `rf_we`=1 → `rf_we` drops to 0 before the next edge and `cnt0`=0.
